apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_master.sv | 132 +++++++++++++
 tb/tb_apb_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared states, register map and widths for the APB master
package apb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_A      = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_B      = 5'd4;
    localparam logic [ADDR_W-1:0] ADDR_RESULT = 5'd8;
    localparam logic [ADDR_W-1:0] ADDR_CMD    = 5'd12;
    localparam logic [ADDR_W-1:0] ADDR_EN     = 5'd16;
    localparam logic [ADDR_W-1:0] ADDR_MAX    = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // Word-aligned and inside the register map
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master fed by a valid/ready request port
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // A bound below one ACCESS cycle is meaningless; nothing is built for it
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q;
`endif

    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        paddr_q  <= req_addr;
                        pwrite_q <= req_write;
                        pwdata_q <= req_wdata;
                        if (addr_legal(req_addr)) begin
                            psel_q  <= 1'b1;
                            state_q <= SETUP;
                        end else begin
                            // Decode error is answered locally; the bus never sees it
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q  <= 1'b1;
                    state_q    <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        state_q     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_MAX) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by presetn so nothing can be accepted while reset is held
    assign req_ready = presetn && (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with an APB register-slave model
module tb_apb_master;
    import apb_pkg::*;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        pclk, presetn;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Peripheral: A, B, RESULT, CMD, EN registers; RESULT reads back A op B when EN[0]
    function automatic logic [31:0] result_of(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] cmd);
        case (cmd[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    logic [31:0] sregs [0:7];
    int          acc_cnt = 0;
    int          wait_n;
    logic        stall, force_rdy;

    assign pready = force_rdy | (psel & penable & !stall & (acc_cnt >= wait_n));

    always_comb begin
        prdata = sregs[paddr[4:2]];
        if (paddr == ADDR_RESULT && sregs[4][0]) prdata = result_of(sregs[0], sregs[1], sregs[3]);
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready && pwrite) sregs[paddr[4:2]] <= pwdata;
    end

    // Reference model of the whole system: register contents as seen through the master
    logic [31:0] mregs [0:4];

    function automatic bit legal_addr(input int a);
        return (a % 4 == 0) && (a <= 16);
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 8 && mregs[4][0]) return result_of(mregs[0], mregs[1], mregs[3]);
        return mregs[a / 4];
    endfunction

    function automatic int lat_of(input int a, input int wt);
        return legal_addr(a) ? 3 + wt : 1;
    endfunction

    // Protocol monitor, sampled on the falling edge
    logic        prev_ok = 1'b0, prev_psel, prev_pen, prev_rdy, prev_wr;
    logic [4:0]  prev_addr;
    logic [31:0] prev_wd;
    logic        allow_drop = 1'b0, psel_seen = 1'b0;

    always @(negedge pclk) begin
        if (psel) psel_seen = 1'b1;
        if (!presetn) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_psel && !prev_pen) begin
                check("setup_one_cycle", {psel, penable}, 2'b11);
                check("setup_stable", {paddr, pwrite, pwdata}, {prev_addr, prev_wr, prev_wd});
            end
            if (prev_ok && prev_psel && prev_pen && !prev_rdy && !allow_drop) begin
                check("access_hold", {psel, penable}, 2'b11);
                check("access_stable", {paddr, pwrite, pwdata}, {prev_addr, prev_wr, prev_wd});
            end
            prev_ok   = 1'b1;
            prev_psel = psel;
            prev_pen  = penable;
            prev_rdy  = pready;
            prev_addr = paddr;
            prev_wr   = pwrite;
            prev_wd   = pwdata;
        end
    end

    task automatic finish_txn(input logic [31:0] er, input logic ee, input int lat,
                              input int bp, input bit no_psel, input string tag);
        int n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!rsp_valid && n < 300);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_rdata"}, rsp_rdata, er);
        check({tag, "_err"}, rsp_err, ee);
        check({tag, "_bus_idle_in_resp"}, {psel, penable}, 2'b00);
        if (no_psel) check({tag, "_no_psel"}, psel_seen, 0);
        force_rdy = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge pclk);
            check({tag, "_bp_stable"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, ee, er});
            check({tag, "_bp_no_ready"}, req_ready, 0);
        end
        force_rdy = 1'b0;
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        check({tag, "_back_to_idle"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic run_txn(input logic w, input logic [4:0] a, input logic [31:0] d, input int wt,
                           input int bp, input logic [31:0] er, input logic ee, input int lat,
                           input string tag);
        int n = 0;
        @(negedge pclk);
        wait_n    = wt;
        psel_seen = 1'b0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check({tag, "_accept"}, req_ready, 1);
        @(posedge pclk);
        #1 req_valid = 1'b0;
        finish_txn(er, ee, lat, bp, !legal_addr(int'(a)), tag);
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        int          wt;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    vec_t vt [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    initial begin
        presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; stall = 1'b0; force_rdy = 1'b0; wait_n = 0;
        for (int i = 0; i < 8; i++) sregs[i] = '0;
        for (int i = 0; i < 5; i++) mregs[i] = '0;

        vt[0]  = '{1'b1, ADDR_A,      32'd5,      0, 32'd0, 1'b0};
        vt[1]  = '{1'b1, ADDR_B,      32'd3,      1, 32'd0, 1'b0};
        vt[2]  = '{1'b1, ADDR_CMD,    32'd0,      0, 32'd0, 1'b0};
        vt[3]  = '{1'b1, ADDR_EN,     32'd1,      2, 32'd0, 1'b0};
        vt[4]  = '{1'b0, ADDR_RESULT, 32'd0,      0, 32'd8, 1'b0};
        vt[5]  = '{1'b0, 5'd6,        32'd0,      0, 32'd0, 1'b1};
        vt[6]  = '{1'b1, 5'd20,       32'hdead,   0, 32'd0, 1'b1};
        vt[7]  = '{1'b0, ADDR_A,      32'd0,      2, 32'd5, 1'b0};
        vt[8]  = '{1'b0, ADDR_EN,     32'd0,      1, 32'd1, 1'b0};
        vt[9]  = '{1'b0, 5'd17,       32'd0,      0, 32'd0, 1'b1};
        vt[10] = '{1'b0, ADDR_B,      32'd0,      0, 32'd3, 1'b0};

        repeat (3) @(negedge pclk);
        check("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, req_ready, paddr}, 0);
        check("reset_pwdata", pwdata, 0);
        check("reset_rdata", rsp_rdata, 0);
        #2 presetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_txn(vt[i].w, vt[i].a, vt[i].d, vt[i].wt, 0, vt[i].er, vt[i].ee,
                    lat_of(int'(vt[i].a), vt[i].wt), $sformatf("vec%0d", i));
            if (vt[i].w && legal_addr(int'(vt[i].a))) mregs[vt[i].a / 4] = vt[i].d;
        end

        // Response backpressure with stray pready pulses while in RESP
        run_txn(1'b0, ADDR_RESULT, 32'd0, 1, 5, model_read(8), 1'b0, lat_of(8, 1), "bp");

        // Reset during ACCESS abandons the transfer
        @(negedge pclk);
        stall = 1'b1; req_write = 1'b0; req_addr = ADDR_A; req_valid = 1'b1;
        @(posedge pclk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge pclk);
        check("rst_reached_access", {psel, penable}, 2'b11);
        #2 presetn = 1'b0;
        #1 check("rst_async_outputs", {psel, penable, rsp_valid, req_ready}, 0);
        stall = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            check("rst_no_response", rsp_valid, 0);
        end
        psel_seen = 1'b0;
        req_write = 1'b0; req_addr = ADDR_B; req_valid = 1'b1; wait_n = 0;
        #1 presetn = 1'b1;
        @(posedge pclk);
        #1 req_valid = 1'b0;
        check("first_edge_accept", {psel, penable}, 2'b10);
        finish_txn(mregs[1], 1'b0, 3, 0, 1'b0, "post_rst");

`ifdef APB_MASTER_TIMEOUT_EN
        allow_drop = 1'b1;
        stall = 1'b1;
        run_txn(1'b0, ADDR_A, 32'd0, 0, 3, 32'd0, 1'b1, 2 + TO, "timeout");
        stall = 1'b0;
        allow_drop = 1'b0;
        run_txn(1'b0, ADDR_A, 32'd0, 0, 0, mregs[0], 1'b0, 3, "after_timeout");
`endif

        for (int k = 0; k < 40; k++) begin
            logic        w;
            logic [4:0]  a;
            logic [31:0] d, er;
            int          wt;
            bit          lg;
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(4 * $urandom_range(0, 4));
            d  = 32'($urandom_range(0, 255));
            wt = $urandom_range(0, 2);
            lg = legal_addr(int'(a));
            er = (lg && !w) ? model_read(int'(a)) : 32'd0;
            run_txn(w, a, d, wt, k % 3, er, !lg, lat_of(int'(a), wt), $sformatf("rnd%0d", k));
            if (lg && w) mregs[a / 4] = d;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
